// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt source controller: FSM states,
// default vector layout and the irq_id width helper.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam logic [31:0] VEC_BASE_DEFAULT   = 32'h0000_0100;
  localparam logic [31:0] VEC_STRIDE_DEFAULT = 32'h0000_0010;

  // Width of irq_id; a single source still gets a 1-bit index.
  function automatic int irq_id_w(input int n_src);
    return (n_src > 1) ? $clog2(n_src) : 1;
  endfunction

endpackage

// File: rtl/irq_debounce.sv
// Per-source input conditioning: 2-flop synchroniser, optional debouncer
// (IRQ_DEBOUNCE_EN) and a one-cycle rising-edge pulse on the settled level.
module irq_debounce
  import irq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic src,
  output logic rise
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("irq_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  logic sync1;
  logic sync2;
  logic level;
  logic level_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the
  // synchroniser into a single stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
    end
  end

`ifdef IRQ_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // The level follows the synchronised input only after an unbroken run of
  // differing samples; one agreeing sample restarts the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt source controller driving the CP0 request/ack/ERET handshake.
// Input debouncing is present only when IRQ_DEBOUNCE_EN is defined.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int          N_SRC           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] VEC_BASE        = VEC_BASE_DEFAULT,
  parameter logic [31:0] VEC_STRIDE      = VEC_STRIDE_DEFAULT,
  localparam int         ID_W            = irq_id_w(N_SRC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_in,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  output logic [N_SRC-1:0] mask,
  output logic [N_SRC-1:0] pending,
  output logic             ir_out,
  input  logic             ir_ack,
  input  logic             eoi,
  output logic [ID_W-1:0]  irq_id,
  output logic [31:0]      vec_addr
);

  if (N_SRC < 1 || N_SRC > 8) begin : g_bad_cfg
    $error("irq_ctrl: N_SRC must be in 1..8");
  end

  logic [N_SRC-1:0] rise;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    irq_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk (clk),
      .rst (rst),
      .src (src_in[i]),
      .rise(rise[i])
    );
  end

  irq_state_t       state;
  irq_state_t       state_n;
  logic [ID_W-1:0]  irq_id_n;
  logic [N_SRC-1:0] pending_n;
  logic [N_SRC-1:0] active;
  logic             ack_take;

  assign active = pending & mask;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_n  = state;
    irq_id_n = irq_id;
    ack_take = 1'b0;
    case (state)
      IDLE: begin
        if (|active) begin
          state_n = REQ;
          // Walk downwards so the lowest enabled index is the one kept.
          for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) irq_id_n = ID_W'(i);
          end
        end
      end
      REQ: begin
        if (ir_ack) begin
          ack_take = 1'b1;
          state_n  = SERVICE;
        end else if (!mask[irq_id]) begin
          state_n = IDLE;
        end
      end
      SERVICE: begin
        if (eoi) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // A new edge on the bit being acknowledged survives the clear.
  always_comb begin
    pending_n = pending;
    if (ack_take) pending_n[irq_id] = 1'b0;
    pending_n = pending_n | rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      irq_id  <= '0;
      mask    <= '1;
      pending <= '0;
    end else begin
      state   <= state_n;
      irq_id  <= irq_id_n;
      pending <= pending_n;
      if (mask_we) mask <= mask_wdata;
    end
  end

  assign ir_out   = (state == REQ);
  assign vec_addr = VEC_BASE + 32'(irq_id) * VEC_STRIDE;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed timing/corner checks plus
// randomized rounds scored against a set-based model of pending sources.
module tb_irq_ctrl;

  localparam int N  = 4;
  localparam int DB = 16;
`ifdef IRQ_DEBOUNCE_EN
  localparam int LAT = 3 + DB;
`else
  localparam int LAT = 3;
`endif
  localparam int HOLD   = DB + 4;
  localparam int SETTLE = DB + 6;

  logic         clk;
  logic         rst;
  logic [N-1:0] src_in;
  logic         mask_we;
  logic [N-1:0] mask_wdata;
  logic [N-1:0] mask;
  logic [N-1:0] pending;
  logic         ir_out;
  logic         ir_ack;
  logic         eoi;
  logic [1:0]   irq_id;
  logic [31:0]  vec_addr;

  irq_ctrl #(
    .N_SRC          (N),
    .DEBOUNCE_CYCLES(DB),
    .VEC_BASE       (32'h0000_0100),
    .VEC_STRIDE     (32'h0000_0010)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src_in    (src_in),
    .mask_we   (mask_we),
    .mask_wdata(mask_wdata),
    .mask      (mask),
    .pending   (pending),
    .ir_out    (ir_out),
    .ir_ack    (ir_ack),
    .eoi       (eoi),
    .irq_id    (irq_id),
    .vec_addr  (vec_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           exp_q[$];
  logic [N-1:0] model_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Requests the DUT must present, lowest index first.
  task automatic push_order(input logic [N-1:0] bits);
    for (int i = 0; i < N; i++) if (bits[i]) exp_q.push_back(i);
  endtask

  task automatic write_mask(input logic [N-1:0] v);
    mask_wdata = v;
    mask_we    = 1'b1;
    tick(1);
    mask_we    = 1'b0;
  endtask

  task automatic pulse_src(input logic [N-1:0] bits, input int hold);
    src_in = bits;
    tick(hold);
    src_in = '0;
  endtask

  task automatic wait_ir();
    int n = 0;
    while (!ir_out && n < 200) begin
      tick(1);
      n++;
    end
    check("req_seen", 32'(ir_out), 32'd1);
  endtask

  task automatic service(input int id);
    wait_ir();
    check("svc_id", 32'(irq_id), 32'(id));
    check("svc_vec", vec_addr, 32'h100 + 32'(id) * 32'h10);
    ir_ack = 1'b1;
    tick(1);
    ir_ack = 1'b0;
    check("svc_drop", 32'(ir_out), 32'd0);
    tick(2);
    eoi = 1'b1;
    tick(1);
    eoi = 1'b0;
    tick(1);
  endtask

  // CP0 stand-in for random rounds: random ack delay with stray ERETs in REQ.
  task automatic respond(input int cnt);
    int d;
    for (int k = 0; k < cnt; k++) begin
      wait_ir();
      d = $urandom_range(0, 4);
      repeat (d) begin
        eoi = 1'($urandom_range(0, 1));
        tick(1);
      end
      eoi    = 1'b0;
      ir_ack = 1'b1;
      tick(1);
      ir_ack = 1'b0;
      tick($urandom_range(1, 5));
      eoi = 1'b1;
      tick(1);
      eoi = 1'b0;
      tick(1);
    end
  endtask

  // Monitor: every new request is popped from the scoreboard and compared.
  initial begin : monitor
    logic prev;
    int   id;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (ir_out && !prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_req", 32'(irq_id), 32'hFFFF_FFFF);
          end else begin
            id = exp_q.pop_front();
            check("mon_id", 32'(irq_id), 32'(id));
            check("mon_vec", vec_addr, 32'h100 + 32'(id) * 32'h10);
          end
        end
        prev = ir_out;
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [N-1:0] m;
    logic [N-1:0] s;
    logic [N-1:0] ord;

    rst        = 1'b1;
    src_in     = 4'b1111;
    mask_we    = 1'b0;
    mask_wdata = '0;
    ir_ack     = 1'b0;
    eoi        = 1'b0;
    model_pend = '0;
    tick(2);
    rst    = 1'b0;
    src_in = '0;

    // Reset values
    check("rst_mask", 32'(mask), 32'hF);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_ir_out", 32'(ir_out), 32'h0);
    check("rst_irq_id", 32'(irq_id), 32'h0);
    check("rst_vec", vec_addr, 32'h100);
    tick(LAT + 3);
    check("rst_no_pend", 32'(pending), 32'h0);

    // Single source latency and ack timing
    exp_q.push_back(2);
    src_in = 4'b0100;
    tick(LAT - 1);
    check("lat_pre", 32'(pending), 32'h0);
    tick(1);
    check("lat_pend", 32'(pending), 32'h4);
    check("lat_ir_pre", 32'(ir_out), 32'h0);
    tick(1);
    check("lat_ir", 32'(ir_out), 32'h1);
    check("lat_id", 32'(irq_id), 32'h2);
    check("lat_vec", vec_addr, 32'h120);
    tick(5);
    ir_ack = 1'b1;
    tick(1);
    ir_ack = 1'b0;
    src_in = '0;
    check("ack_pend", 32'(pending), 32'h0);
    check("ack_ir", 32'(ir_out), 32'h0);
    eoi = 1'b1;
    tick(1);
    eoi = 1'b0;
    tick(3);
    check("eoi_idle", 32'(ir_out), 32'h0);
    tick(SETTLE);

`ifdef IRQ_DEBOUNCE_EN
    // Bouncing line never settles, then a clean 20-cycle press
    for (int k = 0; k < 12; k++) begin
      src_in[0] = ~src_in[0];
      tick(5);
    end
    src_in = '0;
    tick(SETTLE);
    check("bounce_pend", 32'(pending), 32'h0);
    exp_q.push_back(0);
    pulse_src(4'b0001, 20);
    service(0);
    check("press_pend", 32'(pending), 32'h0);
    check("press_once", 32'(ir_out), 32'h0);
    tick(SETTLE);
`endif

    // Priority and queueing
    push_order(4'b1010);
    pulse_src(4'b1010, HOLD);
    check("prio_pend", 32'(pending), 32'hA);
    service(1);
    check("prio_left", 32'(pending), 32'h8);
    service(3);
    check("prio_done", 32'(pending), 32'h0);
    tick(SETTLE);

    // Mask gating, unmask, and mask-clear during REQ
    write_mask(4'b1101);
    pulse_src(4'b0010, HOLD);
    tick(3);
    check("mask_no_ir", 32'(ir_out), 32'h0);
    check("mask_pend", 32'(pending), 32'h2);
    exp_q.push_back(1);
    write_mask(4'b1111);
    tick(1);
    check("unmask_ir", 32'(ir_out), 32'h1);
    check("unmask_id", 32'(irq_id), 32'h1);
    mask_wdata = 4'b1101;
    mask_we    = 1'b1;
    tick(1);
    mask_we = 1'b0;
    tick(1);
    check("remask_drop", 32'(ir_out), 32'h0);
    check("remask_pend", 32'(pending), 32'h2);
    exp_q.push_back(1);
    write_mask(4'b1111);
    service(1);
    check("remask_done", 32'(pending), 32'h0);
    tick(SETTLE);

    // eoi in REQ ignored; new edge in the ack cycle keeps pending set
    exp_q.push_back(0);
    exp_q.push_back(0);
    src_in = 4'b0001;
    wait_ir();
    src_in = '0;
    eoi = 1'b1;
    tick(1);
    eoi = 1'b0;
    check("eoi_in_req", 32'(ir_out), 32'h1);
    tick(SETTLE);
    check("req_held", 32'(ir_out), 32'h1);
    src_in = 4'b0001;
    tick(LAT - 1);
    ir_ack = 1'b1;
    tick(1);
    ir_ack = 1'b0;
    src_in = '0;
    check("set_wins", 32'(pending), 32'h1);
    check("set_wins_ir", 32'(ir_out), 32'h0);
    ir_ack = 1'b1;
    tick(1);
    ir_ack = 1'b0;
    tick(1);
    check("svc_ack_ign", 32'(ir_out), 32'h0);
    eoi = 1'b1;
    tick(1);
    eoi = 1'b0;
    service(0);
    check("corner_done", 32'(pending), 32'h0);
    tick(SETTLE);

    // Reset while in SERVICE
    exp_q.push_back(2);
    src_in = 4'b0100;
    wait_ir();
    src_in = '0;
    ir_ack = 1'b1;
    tick(1);
    ir_ack = 1'b0;
    write_mask(4'b0000);
    pulse_src(4'b1000, HOLD);
    tick(2);
    check("svc_pend", 32'(pending), 32'h8);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("srst_mask", 32'(mask), 32'hF);
    check("srst_pend", 32'(pending), 32'h0);
    check("srst_ir", 32'(ir_out), 32'h0);
    check("srst_id", 32'(irq_id), 32'h0);
    tick(4);
    check("srst_idle", 32'(ir_out), 32'h0);
    tick(SETTLE);

    // Randomized rounds against the set model
    model_pend = '0;
    for (int r = 0; r < 10; r++) begin
      m   = 4'($urandom_range(0, 15));
      s   = 4'($urandom_range(1, 15));
      ord = model_pend & m;
      push_order(ord);
      model_pend = model_pend & ~m;
      write_mask(m);
      respond($countones(ord));
      tick(3);
`ifdef IRQ_DEBOUNCE_EN
      src_in = 4'($urandom_range(0, 15));
      tick($urandom_range(1, DB - 4));
      src_in = '0;
      tick(4);
`endif
      ord = (model_pend | s) & m;
      push_order(ord);
      model_pend = (model_pend | s) & ~m;
      pulse_src(s, HOLD + $urandom_range(0, 5));
      respond($countones(ord));
      tick(SETTLE);
      check("round_pend", 32'(pending), 32'(model_pend));
      check("round_idle", 32'(ir_out), 32'h0);
    end

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt source controller feeding the CP0 external-interrupt input; it is the requesting end of the CP0 interrupt handshake.
- Synchronises and debounces N raw push-button/peripheral lines, then latches rising edges as pending bits and applies a software mask.
- Picks one source by fixed priority, raises a request to CP0, and holds it until CP0 takes the interrupt.
- Then waits for ERET (end-of-interrupt) before issuing the next request.

Parameters:
- N_SRC, 4, number of interrupt sources (1..8).
- DEBOUNCE_CYCLES, 16, consecutive stable samples required to accept a level change (>=1).
- VEC_BASE, 32'h0000_0100, handler vector base address.
- VEC_STRIDE, 32'h0000_0010, byte spacing between per-source vectors.

Ports:
- clk  in  1  main clock
- rst  in  1  synchronous reset, active-high
- src_in  in  N_SRC  raw asynchronous source lines, active-high
- mask_we  in  1  write strobe for the mask register
- mask_wdata  in  N_SRC  new mask value (1 = enabled)
- mask  out  N_SRC  current mask register
- pending  out  N_SRC  latched pending bits
- ir_out  out  1  interrupt request to CP0 ir_in
- ir_ack  in  1  CP0 accepted the interrupt (CP0 jump taken for interrupt)
- eoi  in  1  ERET executed (CP0 oper == ERET)
- irq_id  out  $clog2(N_SRC) (min 1)  index of the source being requested/serviced
- vec_addr  out  32  VEC_BASE + irq_id*VEC_STRIDE

Behaviour:
- Reset (synchronous, highest priority over all other inputs):
  - mask = all ones; pending = 0; ir_out = 0; irq_id = 0; state = IDLE.
  - Sync flops, debounced levels and debounce counters are cleared.
- Input conditioning, per source:
  - 2-flop synchroniser feeds the debouncer.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive synchronised samples differ from the current level; any equal sample restarts the count.
  - A 0->1 change of the debounced level is an edge and sets pending[i] on the next clock edge.
  - Latency: src_in held high from cycle 0 makes pending[i] visible at cycle 3+DEBOUNCE_CYCLES.
- Pending:
  - Set by edge. Cleared only when ir_ack arrives in REQ, and only for bit irq_id.
  - Simultaneous set and clear of the same bit: set wins.
  - Masked sources still latch pending.
- Mask: when mask_we is high, mask <= mask_wdata on the next clock edge.
- FSM:
  - IDLE: if (pending & mask) != 0, latch irq_id = lowest set index, go to REQ. ir_out is high from the next cycle. eoi and ir_ack are ignored.
  - REQ: ir_out = 1.
    - On ir_ack: clear pending[irq_id], ir_out = 0 next cycle, go to SERVICE.
    - If mask[irq_id] is 0 (and no ack that cycle): ir_out = 0 next cycle, return to IDLE, pending kept.
    - ack and mask-clear in the same cycle: ack wins.
    - eoi is ignored.
  - SERVICE: ir_out = 0, irq_id held. On eoi, go to IDLE. ir_ack is ignored.
- Re-request: earliest new ir_out is 2 cycles after eoi (IDLE evaluation, then REQ).
- irq_id does not change while in REQ or SERVICE; vec_addr is combinational from irq_id.
- Edges arriving during REQ/SERVICE accumulate in pending; multiple edges on one source before service collapse into one.

Optional Feature:
- IRQ_DEBOUNCE_EN defined: debouncer present as described.
- Not defined: debouncer is removed. The edge is taken directly from the synchroniser output, so src_in high at cycle 0 makes pending visible at cycle 3. DEBOUNCE_CYCLES is unused.

Decomposition:
- Shared package (irq_pkg):
  - FSM state encoding (IDLE, REQ, SERVICE).
  - Default values of VEC_BASE and VEC_STRIDE.
  - A clog2-based IRQ_ID_W helper.
- Sub-module irq_debounce: one instance per source. Contains the synchroniser, debounce counter and rising-edge pulse output. Parameterised by DEBOUNCE_CYCLES and compiled per IRQ_DEBOUNCE_EN.

Test Plan:
- Reset: rst high 2 cycles with src_in=4'b1111 -> mask=4'b1111, pending=0, ir_out=0, irq_id=0; no pending within DEBOUNCE_CYCLES+3 cycles after release unless a debounced edge occurs.
- Single source, DEBOUNCE_CYCLES=16: src_in[2] high at cycle 0 -> pending=4'b0100 at cycle 19, ir_out=1 at cycle 20, irq_id=2, vec_addr=32'h120. ir_ack at cycle 25 -> pending=0 and ir_out=0 at cycle 26. eoi -> state IDLE.
- Bounce: src_in[0] toggling every 5 cycles for 60 cycles, then low -> pending stays 0. Held high 20 cycles -> exactly one pending set.
- Priority/queueing: sources 1 and 3 pending together -> irq_id=1 first. After ack+eoi, second request with irq_id=3, vec_addr=32'h130.
- Mask: mask_wdata=4'b1101 with source 1 pending -> no ir_out. Writing mask=4'b1111 -> ir_out within 2 cycles. Clearing mask bit during REQ -> ir_out drops, pending retained.
- Corner cases: edge on source 0 in the same cycle as ir_ack for irq_id=0 -> pending[0] stays 1. eoi while in REQ -> ignored, ir_out stays 1. rst asserted in SERVICE -> IDLE, all outputs at reset values.
